cmd_encoder_rr: RTL and testbench
=================================

// Module: cmd_encoder_rr
// PURPOSE
//  Parametrised response encoder between the slave blocks and the UART TX.
//  Scans N_SRC slave message queues, grants one by round-robin, and serialises
//  a framed reply: SYNC, ADDR, LEN, LEN payload bytes, optional checksum.
//  It drives an AXI-stream-style byte handshake into the UART.
//  It generalises the fixed-priority encoder with arbitrary channel count,
//  fairness, configurable length width and explicit framing.
// PARAMETERS
//  N_SRC      24     number of slave channels (1..256); the channel index is the ADDR byte
//  LEN_W      8      width of each len_bus field; payload length 0..2^LEN_W-1
//  SYNC_BYTE  8'hA5  first byte of every frame
// PORTS
//  clk           in   1            system clock
//  n_rst         in   1            asynchronous active-low reset
//  have_msg_bus  in   N_SRC        per-channel message pending
//  data_bus      in   8*N_SRC      per-channel show-ahead head byte, valid while queue non-empty
//  len_bus       in   LEN_W*N_SRC  per-channel payload length, valid while have_msg high
//  rdreq_bus     out  N_SRC        per-channel one-cycle pop strobe
//  tx_data       out  8            byte to UART
//  tx_valid      out  1            tx_data valid
//  tx_ready      in   1            UART accepts the byte when tx_valid && tx_ready
// BEHAVIOUR
//  Reset values: tx_valid=0, tx_data=8'h00, rdreq_bus=0, state=IDLE, rr pointer=0, checksum=0.
//  Reset asserted mid-frame aborts the frame immediately. No partial-frame resume after reset.
//  FSM states: IDLE -> SYNC -> ADDR -> LEN -> DATA -> (CSUM) -> IDLE.
//  IDLE:
//   - Search have_msg_bus from pointer p upward, wrapping modulo N_SRC.
//   - The first set bit k wins. Register grant=k and cnt=len_bus[k].
//   - Next cycle: state=SYNC, tx_valid=1, tx_data=SYNC_BYTE. Latency from have_msg to tx_valid is 1 clk.
//  Byte transfers:
//   - A byte transfers only on tx_valid && tx_ready.
//   - tx_data and tx_valid stay stable until the transfer. tx_valid never drops without a transfer.
//  Sequence after transfers: ADDR sends grant[7:0]; LEN sends cnt (LEN_W>8: low byte then high byte).
//  Length 0: after LEN, go to CSUM if enabled, else IDLE. Otherwise go to DATA.
//  DATA:
//   - tx_data = data_bus[8*grant+:8].
//   - On each transfer, rdreq_bus[grant] pulses for exactly 1 clk and cnt decrements.
//   - The last byte (cnt==1) moves to CSUM or IDLE.
//   - Only the granted channel ever sees rdreq. At most one rdreq bit is high per cycle.
//  Back-to-back frames:
//   - On return to IDLE, p = (grant+1) mod N_SRC.
//   - One IDLE cycle always separates frames, so tx_valid deasserts for at least 1 clk.
//  Arbitration and queue rules:
//   - have_msg changes during a frame are ignored. The latched cnt governs the frame.
//   - Simultaneous requests resolve by the rotating order above. No channel waits more than N_SRC-1 frames.
//   - The upstream slave guarantees its queue holds cnt bytes when have_msg rises. No underflow detection.
//  tx_ready may stay low indefinitely; the block holds its state with no timeout.
// CONFIGURATION
//  Macro ENC_CHECKSUM_EN:
//   - Defined: an 8-bit XOR of the ADDR, LEN and payload bytes accumulates as each byte transfers.
//     The CSUM state sends that XOR after the last payload byte (or after LEN when length is 0).
//     The accumulator clears on entry to SYNC.
//   - Undefined: the CSUM state and accumulator are absent. The frame ends after the payload.
// TESTING
//  1) Reset with have_msg=0 -> tx_valid=0, rdreq_bus=0 indefinitely; outputs at reset values.
//  2) ch3 len=2 data {11,22}, tx_ready=1 -> tx stream A5,03,02,11,22.
//     With ENC_CHECKSUM_EN the stream adds 32 (03^02^11^22).
//     rdreq_bus[3] pulses on the 11 and 22 transfers.
//  3) ch0,ch5,ch9 request together, p=0, each len=1 -> frames in order 00,05,09.
//     Then ch0 and ch9 re-request with p=10 -> order 00,09.
//  4) ch7 len=0 -> frame A5,07,00 (plus 07 with checksum) and no rdreq.
//  5) tx_ready toggled randomly during ch2 len=4 -> tx_data stable while stalled.
//     Exactly 4 rdreq pulses; the byte sequence matches the no-stall case.
//  6) n_rst asserted during DATA byte 2 of 5 -> tx_valid=0 in the same cycle.
//     After release, a new request from ch1 starts cleanly with A5.

Source files
------------

// File: rtl/cmd_encoder_rr.sv
// cmd_encoder_rr: round-robin framed reply encoder from N_SRC slave queues to a UART byte stream
// Frame: SYNC_BYTE, ADDR (channel index), LEN (LEN_W bits, low byte first), payload, optional checksum.
// Ports: clk, n_rst (async active-low); have_msg_bus / data_bus (show-ahead head) / len_bus per channel;
//   rdreq_bus per-channel pop strobe; tx_data / tx_valid / tx_ready byte handshake into the UART.
// Define ENC_CHECKSUM_EN to append a CSUM byte: XOR of the ADDR, LEN and payload bytes.
module cmd_encoder_rr #(
  parameter int N_SRC = 24,
  parameter int LEN_W = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [N_SRC-1:0]       have_msg_bus,
  input  logic [8*N_SRC-1:0]     data_bus,
  input  logic [LEN_W*N_SRC-1:0] len_bus,
  output logic [N_SRC-1:0]       rdreq_bus,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready
);
  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int NLB = (LEN_W + 7) / 8;
  typedef enum logic [2:0] {IDLE, SYNC, ADDR, LEN, DATA, CSUM} state_t;
  state_t state;
  logic [GW-1:0] ptr, grant, win, nxt_ptr;
  logic [GW:0] s;
  logic hit, xfer, pay_end;
  logic [LEN_W-1:0] cnt;
  logic [8*NLB-1:0] len_sh, len_nx;
  logic [7:0] lb, tx_q, head;
  logic [7:0] data_arr [N_SRC];
  logic [LEN_W-1:0] len_arr [N_SRC];
`ifdef ENC_CHECKSUM_EN
  logic [7:0] csum;
`endif
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      data_arr[i] = data_bus[8*i +: 8];
      len_arr[i] = len_bus[LEN_W*i +: LEN_W];
    end
  end
  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win = ptr;
    hit = 1'b0;
    s = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (GW+1)'(i);
      s = (s >= (GW+1)'(N_SRC)) ? s - (GW+1)'(N_SRC) : s;
      if (have_msg_bus[s[GW-1:0]]) begin
        win = s[GW-1:0];
        hit = 1'b1;
      end
    end
  end
  assign head = data_arr[grant];
  assign tx_data = (state == DATA) ? head : tx_q;
  assign xfer = tx_valid & tx_ready;
  assign nxt_ptr = (grant == GW'(N_SRC - 1)) ? '0 : grant + GW'(1);
  assign len_nx = len_sh >> 8;
  // Pop lands on the same edge as the transfer, so the next head is shown the following cycle.
  assign rdreq_bus = (state == DATA && xfer) ? N_SRC'(1) << grant : '0;
  assign pay_end = (state == LEN && lb == 8'(NLB - 1) && cnt == '0) || (state == DATA && cnt == LEN_W'(1));
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      cnt <= '0;
      len_sh <= '0;
      lb <= '0;
      tx_q <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          grant <= win;
          cnt <= len_arr[win];
          tx_q <= SYNC_BYTE;
          tx_valid <= 1'b1;
          state <= SYNC;
        end
        SYNC: if (xfer) begin
          tx_q <= 8'(grant);
          state <= ADDR;
        end
        ADDR: if (xfer) begin
          len_sh <= (8*NLB)'(cnt);
          tx_q <= 8'(cnt);
          lb <= 8'd0;
          state <= LEN;
        end
        LEN: if (xfer) begin
          if (lb != 8'(NLB - 1)) begin
            lb <= lb + 8'd1;
            len_sh <= len_nx;
            tx_q <= len_nx[7:0];
          end else state <= DATA;
        end
        DATA: if (xfer) cnt <= cnt - LEN_W'(1);
        CSUM: if (xfer) begin
          state <= IDLE;
          tx_valid <= 1'b0;
          ptr <= nxt_ptr;
        end
        default: state <= IDLE;
      endcase
      // Overrides the case above on the final LEN or payload byte.
      if (xfer && pay_end) begin
`ifdef ENC_CHECKSUM_EN
        state <= CSUM;
        tx_q <= csum ^ tx_data;
`else
        state <= IDLE;
        tx_valid <= 1'b0;
        ptr <= nxt_ptr;
`endif
      end
    end
  end
`ifdef ENC_CHECKSUM_EN
  // Cleared throughout IDLE, which is the same as clearing on entry to SYNC.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) csum <= 8'h00;
    else if (state == IDLE) csum <= 8'h00;
    else if (xfer && (state == ADDR || state == LEN || state == DATA)) csum <= csum ^ tx_data;
  end
`endif
endmodule

// File: tb/tb_cmd_encoder_rr.sv
// tb_cmd_encoder_rr: self-checking bench for cmd_encoder_rr with a queue-based slave and frame model
module tb_cmd_encoder_rr;
  localparam int N = 24;
  logic clk = 1'b0, n_rst = 1'b0, tx_ready = 1'b0;
  logic [N-1:0] have_msg_bus = '0;
  logic [N-1:0] rdreq_bus;
  logic [8*N-1:0] data_bus = '0, len_bus = '0;
  logic [7:0] tx_data;
  logic tx_valid;
  cmd_encoder_rr dut (
    .clk(clk), .n_rst(n_rst), .have_msg_bus(have_msg_bus), .data_bus(data_bus), .len_bus(len_bus),
    .rdreq_bus(rdreq_bus), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    int ch;
    int len;
    logic [31:0] d;
    logic [7:0] cs;
    int rdy;
  } vec_t;
  vec_t tbl [6];
  int n_chk = 0, n_err = 0;
  logic [7:0] dataq [0:N-1][$];
  int lenq [0:N-1][$];
  logic [7:0] exp_frame[$], got[$], tq[$];
  int addr_log[$];
  int p_model = 0, cur = 0, cur_len = 0, fpos = 0, rd_cnt = 0, rdy_pct = 100;
  int pop_addr = -1, pop_data = -1;
  bit in_frame = 0, prev_valid = 0, stall = 0, ok;
  logic [7:0] stall_data = 8'h00;
  logic [N-1:0] hm_prev = '0;
  function automatic void chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endfunction
  function automatic bit all_empty();
    for (int c = 0; c < N; c++) if (lenq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction
  function automatic void drive_bus();
    for (int c = 0; c < N; c++) begin
      have_msg_bus[c] = lenq[c].size() != 0;
      len_bus[8*c +: 8] = (lenq[c].size() != 0) ? 8'(lenq[c][0]) : 8'h00;
      data_bus[8*c +: 8] = (dataq[c].size() != 0) ? dataq[c][0] : 8'h00;
    end
  endfunction
  task automatic add_msg(input int ch, input int len, input logic [63:0] d);
    lenq[ch].push_back(len);
    for (int i = 0; i < len; i++) dataq[ch].push_back(d[63-8*i -: 8]);
    drive_bus();
  endtask
  // Winner: first pending channel at or after the model pointer, wrapping.
  function automatic void start_frame();
    int w = -1;
`ifdef ENC_CHECKSUM_EN
    logic [7:0] cs;
`endif
    for (int off = 0; off < N; off++) begin
      int c = (p_model + off) % N;
      if (w < 0 && hm_prev[c]) w = c;
    end
    chk("frame_has_requester", 64'(w >= 0), 64'd1);
    if (w < 0) return;
    cur = w;
    cur_len = lenq[w][0];
    exp_frame.delete();
    exp_frame.push_back(8'hA5);
    exp_frame.push_back(8'(w));
    exp_frame.push_back(8'(cur_len));
    for (int i = 0; i < cur_len; i++) exp_frame.push_back(dataq[w][i]);
`ifdef ENC_CHECKSUM_EN
    cs = 8'h00;
    for (int i = 1; i < exp_frame.size(); i++) cs = cs ^ exp_frame[i];
    exp_frame.push_back(cs);
`endif
    in_frame = 1;
    fpos = 0;
  endfunction
  task automatic step();
    logic [N-1:0] exp_rd;
    exp_rd = '0;
    @(negedge clk);
    pop_addr = -1;
    pop_data = -1;
    if (stall) begin
      chk("stall_valid", 64'(tx_valid), 64'd1);
      chk("stall_data", 64'(tx_data), 64'(stall_data));
    end
    if (tx_valid && !in_frame) begin
      chk("frame_gap", 64'(prev_valid), 64'd0);
      start_frame();
    end
    if (in_frame) chk("valid_in_frame", 64'(tx_valid), 64'd1);
    if (in_frame && tx_valid && tx_ready) begin
      chk("tx_byte", 64'(tx_data), 64'(exp_frame[fpos]));
      got.push_back(tx_data);
      if (fpos == 1) begin
        addr_log.push_back(int'(tx_data));
        pop_addr = cur;
      end
      if (fpos >= 3 && fpos < 3 + cur_len) begin
        exp_rd[cur] = 1'b1;
        pop_data = cur;
      end
      fpos++;
      if (fpos == exp_frame.size()) begin
        in_frame = 0;
        p_model = (cur + 1) % N;
      end
    end
    chk("rdreq", 64'(rdreq_bus), 64'(exp_rd));
    rd_cnt += $countones(rdreq_bus);
    stall = tx_valid && !tx_ready;
    stall_data = tx_data;
    prev_valid = tx_valid;
    hm_prev = have_msg_bus;
    @(posedge clk);
    #1;
    if (pop_addr >= 0) void'(lenq[pop_addr].pop_front());
    if (pop_data >= 0) void'(dataq[pop_data].pop_front());
    tx_ready = $urandom_range(0, 99) < rdy_pct;
    drive_bus();
  endtask
  task automatic run_until_idle(input int max);
    ok = 0;
    for (int k = 0; k < max && !ok; k++) begin
      step();
      if (!in_frame && !tx_valid && all_empty()) ok = 1;
    end
    chk("drain_within_budget", 64'(ok), 64'd1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{3, 2, 32'h11220000, 8'h32, 100};
    tbl[1] = '{7, 0, 32'h00000000, 8'h07, 100};
    tbl[2] = '{23, 1, 32'hFF000000, 8'hE9, 100};
    tbl[3] = '{0, 4, 32'h01020408, 8'h0B, 100};
    tbl[4] = '{12, 3, 32'hA55A0000, 8'hF0, 70};
    tbl[5] = '{2, 4, 32'hDEADBEEF, 8'h24, 40};
    drive_bus();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_rdreq", 64'(rdreq_bus), 64'd0);
    n_rst = 1'b1;
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("idle_valid", 64'(tx_valid), 64'd0);
      chk("idle_data", 64'(tx_data), 64'd0);
      chk("idle_rdreq", 64'(rdreq_bus), 64'd0);
    end
    addr_log.delete();
    add_msg(0, 1, {8'hC0, 56'h0});
    add_msg(5, 1, {8'hC5, 56'h0});
    add_msg(9, 1, {8'hC9, 56'h0});
    run_until_idle(100);
    chk("rr_count", 64'(addr_log.size()), 64'd3);
    chk("rr_first", 64'(addr_log.size() > 0 ? addr_log[0] : -1), 64'd0);
    chk("rr_second", 64'(addr_log.size() > 1 ? addr_log[1] : -1), 64'd5);
    chk("rr_third", 64'(addr_log.size() > 2 ? addr_log[2] : -1), 64'd9);
    addr_log.delete();
    add_msg(0, 1, {8'hD0, 56'h0});
    add_msg(9, 1, {8'hD9, 56'h0});
    run_until_idle(100);
    chk("rr_wrap_count", 64'(addr_log.size()), 64'd2);
    chk("rr_wrap_first", 64'(addr_log.size() > 0 ? addr_log[0] : -1), 64'd0);
    chk("rr_wrap_second", 64'(addr_log.size() > 1 ? addr_log[1] : -1), 64'd9);
    foreach (tbl[v]) begin
      got.delete();
      rd_cnt = 0;
      rdy_pct = tbl[v].rdy;
      add_msg(tbl[v].ch, tbl[v].len, {tbl[v].d, 32'h0});
      run_until_idle(300);
      tq.delete();
      tq.push_back(8'hA5);
      tq.push_back(8'(tbl[v].ch));
      tq.push_back(8'(tbl[v].len));
      for (int i = 0; i < tbl[v].len; i++) tq.push_back(tbl[v].d[31-8*i -: 8]);
`ifdef ENC_CHECKSUM_EN
      tq.push_back(tbl[v].cs);
`endif
      chk("vec_len", 64'(got.size()), 64'(tq.size()));
      foreach (tq[i]) chk("vec_byte", 64'(i < got.size() ? got[i] : 8'hXX), 64'(tq[i]));
      chk("vec_rdreq_pulses", 64'(rd_cnt), 64'(tbl[v].len));
    end
    rdy_pct = 100;
    add_msg(4, 5, {40'h0102030405, 24'h0});
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      step();
      if (in_frame && cur == 4 && fpos == 4) ok = 1;
    end
    chk("reached_data_byte2", 64'(ok), 64'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_valid", 64'(tx_valid), 64'd0);
    chk("abort_rdreq", 64'(rdreq_bus), 64'd0);
    chk("abort_data", 64'(tx_data), 64'd0);
    for (int c = 0; c < N; c++) begin
      lenq[c].delete();
      dataq[c].delete();
    end
    in_frame = 0;
    stall = 0;
    prev_valid = 0;
    hm_prev = '0;
    p_model = 0;
    drive_bus();
    repeat (2) step();
    @(posedge clk);
    #1 n_rst = 1'b1;
    got.delete();
    add_msg(1, 1, {8'h77, 56'h0});
    run_until_idle(100);
    chk("restart_sync", 64'(got.size() > 0 ? got[0] : 8'hXX), 64'hA5);
    chk("restart_addr", 64'(got.size() > 1 ? got[1] : 8'hXX), 64'h01);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0)
        add_msg(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 6)), {$urandom, $urandom});
      if (k % 50 == 0) rdy_pct = int'($urandom_range(30, 100));
      step();
    end
    rdy_pct = 100;
    run_until_idle(4000);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
